// File: rtl/bcd_adder_pkg.sv
// rtl/bcd_adder_pkg.sv - shared state type and BCD constants for the digit-serial adder
package bcd_adder_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ADD,
        DONE
    } state_t;

    localparam int         DIGIT_W  = 4;
    localparam logic [3:0] BCD_MAX  = 4'd9;
    localparam logic [3:0] BCD_CORR = 4'd6;

endpackage

// File: rtl/bcd_digit_add.sv
// rtl/bcd_digit_add.sv - combinational single-digit BCD adder with +6 decimal correction
module bcd_digit_add
    import bcd_adder_pkg::*;
(
    input  logic [DIGIT_W-1:0] a,
    input  logic [DIGIT_W-1:0] b,
    input  logic               cin,
    output logic [DIGIT_W-1:0] s,
    output logic               cout,
    output logic               bad
);

    logic [DIGIT_W:0] t;

    always_comb begin
        t = {1'b0, a} + {1'b0, b} + {{DIGIT_W{1'b0}}, cin};
        if (t > {1'b0, BCD_MAX}) begin
            s    = t[DIGIT_W-1:0] + BCD_CORR;
            cout = 1'b1;
        end else begin
            s    = t[DIGIT_W-1:0];
            cout = 1'b0;
        end
        bad = (a > BCD_MAX) || (b > BCD_MAX);
    end

endmodule

// File: rtl/bcd_serial_adder.sv
// rtl/bcd_serial_adder.sv - digit-serial multi-digit BCD adder, one digit per clock, LSD first
// Optional subtract mode (Op port, nines'-complement of B) enabled by macro BCD_SUB_EN.
module bcd_serial_adder
    import bcd_adder_pkg::*;
#(
    parameter int DIGITS = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [DIGIT_W*DIGITS-1:0] a,
    input  logic [DIGIT_W*DIGITS-1:0] b,
    input  logic                      cin,
`ifdef BCD_SUB_EN
    input  logic                      op,
`endif
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [DIGIT_W*DIGITS-1:0] sum,
    output logic                      cout,
    output logic                      err
);

    localparam int W     = DIGIT_W * DIGITS;
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    state_t             state, state_nxt;
    logic [W-1:0]       a_r, b_r;
    logic               carry;
    logic [IDX_W-1:0]   idx;
    logic [DIGIT_W-1:0] da, db, db_eff, ds;
    logic               dcout, dbad, last;
`ifdef BCD_SUB_EN
    logic               op_r;
`endif

    always_comb begin
        da = '0;
        db = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (idx == IDX_W'(i)) begin
                da = a_r[i*DIGIT_W +: DIGIT_W];
                db = b_r[i*DIGIT_W +: DIGIT_W];
            end
        end
    end

    // 9-b wraps to 10..15 for any b in 10..15, so the digit adder's bad flag
    // still reflects the original B digit in subtract mode.
`ifdef BCD_SUB_EN
    assign db_eff = op_r ? (BCD_MAX - db) : db;
`else
    assign db_eff = db;
`endif

    bcd_digit_add u_digit (
        .a    (da),
        .b    (db_eff),
        .cin  (carry),
        .s    (ds),
        .cout (dcout),
        .bad  (dbad)
    );

    assign last      = (idx == IDX_W'(DIGITS - 1));
    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid)  state_nxt = ADD;
            ADD:     if (last)      state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = IDLE;
            default:                state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_r   <= '0;
            b_r   <= '0;
            carry <= 1'b0;
            idx   <= '0;
            sum   <= '0;
            cout  <= 1'b0;
            err   <= 1'b0;
`ifdef BCD_SUB_EN
            op_r  <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_r   <= a;
                        b_r   <= b;
                        idx   <= '0;
                        err   <= 1'b0;
                        sum   <= '0;
`ifdef BCD_SUB_EN
                        op_r  <= op;
                        carry <= op ? 1'b1 : cin;
`else
                        carry <= cin;
`endif
                    end
                end
                ADD: begin
                    for (int i = 0; i < DIGITS; i++) begin
                        if (idx == IDX_W'(i)) sum[i*DIGIT_W +: DIGIT_W] <= ds;
                    end
                    carry <= dcout;
                    err   <= err | dbad;
                    if (last) cout <= dcout;
                    else      idx  <= idx + 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_bcd_serial_adder.sv
// tb/tb_bcd_serial_adder.sv - scoreboard bench for bcd_serial_adder, DIGITS=4
module tb_bcd_serial_adder;

    localparam int DIGITS = 4;
    localparam int W      = 4 * DIGITS;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a, b;
    logic         cin;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         cout;
    logic         err;
`ifdef BCD_SUB_EN
    logic         op;
`endif

    bcd_serial_adder #(.DIGITS(DIGITS)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
`ifdef BCD_SUB_EN
        .op        (op),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .err       (err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [W-1:0] sum;
        logic         cout;
        logic         err;
        int           acc;
        string        name;
    } exp_t;

    exp_t sb[$];

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    logic prev_ov = 1'b0;

    always @(negedge clk) begin
        if (!rst) begin
            if (out_valid && !prev_ov) begin
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_output: got sum=%h with no pending operation", sum);
                end else begin
                    chk({sb[0].name, "_latency"}, W'(cyc - sb[0].acc), W'(DIGITS));
                end
            end
            if (out_valid && out_ready && sb.size() > 0) begin
                chk({sb[0].name, "_sum"},  sum,             sb[0].sum);
                chk({sb[0].name, "_cout"}, W'(cout),        W'(sb[0].cout));
                chk({sb[0].name, "_err"},  W'(err),         W'(sb[0].err));
                sb.delete(0);
            end
        end
        prev_ov <= out_valid;
    end

    task automatic send(input string name, input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                        input logic tcin, input logic top, input logic push,
                        input logic [W-1:0] esum, input logic ecout, input logic eerr);
        int n = 0;
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            total++;
            bad++;
            $display("FAIL %s_accept_timeout: in_ready=%b want 1", name, in_ready);
            return;
        end
        a   = ta;
        b   = tb_v;
        cin = tcin;
`ifdef BCD_SUB_EN
        op  = top;
`else
        if (top) $display("note: op ignored in add-only build");
`endif
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        if (push) sb.push_back('{esum, ecout, eerr, cyc, name});
    endtask

    task automatic drain();
        int n = 0;
        while ((sb.size() > 0 || out_valid) && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() > 0) begin
            total++;
            bad++;
            $display("FAIL drain_timeout: pending=%0d want 0", sb.size());
        end
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        a         = '0;
        b         = '0;
        cin       = 1'b0;
        out_ready = 1'b1;
`ifdef BCD_SUB_EN
        op        = 1'b0;
`endif
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready",  W'(in_ready),  W'(1));
        chk("rst_out_valid", W'(out_valid), W'(0));
        chk("rst_sum",       sum,           W'(0));
        chk("rst_cout",      W'(cout),      W'(0));
        chk("rst_err",       W'(err),       W'(0));
        rst = 1'b0;
        @(posedge clk);
        #1;

        send("basic",   16'h1234, 16'h5678, 1'b0, 1'b0, 1'b1, 16'h6912, 1'b0, 1'b0);
        send("ripple",  16'h9999, 16'h0001, 1'b0, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0);
        send("mixed",   16'h4567, 16'h4433, 1'b0, 1'b0, 1'b1, 16'h9000, 1'b0, 1'b0);
        send("maxcin",  16'h9999, 16'h9999, 1'b1, 1'b0, 1'b1, 16'h9999, 1'b1, 1'b0);
        send("err_a",   16'h00A0, 16'h0000, 1'b0, 1'b0, 1'b1, 16'h0100, 1'b0, 1'b1);
        send("err_b",   16'h0001, 16'h000F, 1'b0, 1'b0, 1'b1, 16'h0016, 1'b0, 1'b1);
        drain();

        // back-pressure: result must hold and a second request must be ignored
        out_ready = 1'b0;
        send("bp", 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b1, 16'h0001, 1'b0, 1'b0);
        begin
            int n = 0;
            while (!out_valid && n < 50) begin
                @(negedge clk);
                n++;
            end
        end
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("bp_hold_sum", sum,              W'(16'h0001));
            chk("bp_in_ready", W'(in_ready),     W'(0));
            if (k == 1) begin
                a        = 16'h5555;
                b        = 16'h1111;
                in_valid = 1'b1;
            end
            if (k == 2) in_valid = 1'b0;
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("bp_release_in_ready",  W'(in_ready),  W'(1));
        chk("bp_release_out_valid", W'(out_valid), W'(0));
        drain();

        // reset during the second ADD cycle aborts the operation
        send("aborted", 16'h1111, 16'h2222, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            chk("abort_out_valid", W'(out_valid), W'(0));
        end
        chk("abort_in_ready", W'(in_ready), W'(1));
        chk("abort_sum",      sum,          W'(0));
        send("after_rst", 16'h0005, 16'h0005, 1'b0, 1'b0, 1'b1, 16'h0010, 1'b0, 1'b0);

`ifdef BCD_SUB_EN
        send("sub_pos", 16'h0500, 16'h0123, 1'b0, 1'b1, 1'b1, 16'h0377, 1'b1, 1'b0);
        send("sub_neg", 16'h0123, 16'h0500, 1'b1, 1'b1, 1'b1, 16'h9623, 1'b0, 1'b0);
        send("add_op0", 16'h1234, 16'h5678, 1'b0, 1'b0, 1'b1, 16'h6912, 1'b0, 1'b0);
`endif
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/bcd_serial_adder.md
Name: bcd_serial_adder

Overview:
- Parametrised, digit-serial multi-digit BCD adder for the BCD arithmetic path.
- Accepts two DIGITS-digit packed-BCD operands over a valid/ready handshake and processes one decimal digit per clock, LSD first, with decimal (+6) correction.
- Returns the BCD sum and decimal carry-out over a second valid/ready handshake.
- Flags any operand digit above 9.

Parameters:
- DIGITS, 4, number of BCD digits per operand; legal range 1..16; operand width = 4*DIGITS.

Ports:
- Clk  input  1  system clock, rising edge.
- Rst  input  1  asynchronous, active-high reset.
- In_Valid  input  1  operands A, B, Cin are valid.
- In_Ready  output  1  block can accept operands.
- A  input  4*DIGITS  packed-BCD operand A; digit 0 is bits [3:0].
- B  input  4*DIGITS  packed-BCD operand B.
- Cin  input  1  decimal carry-in to digit 0.
- Out_Valid  output  1  Sum, Cout and Err are valid.
- Out_Ready  input  1  consumer accepts the result.
- Sum  output  4*DIGITS  packed-BCD result.
- Cout  output  1  decimal carry out of the most significant digit.
- Err  output  1  at least one operand digit was greater than 9.

Behaviour:
- Clocking and reset: one clock (Clk). Rst is asynchronous and active-high.
- Reset values: state=IDLE, In_Ready=1, Out_Valid=0, Sum=0, Cout=0, Err=0, digit index=0, carry register=0.
- FSM states: IDLE, ADD, DONE. In_Ready is 1 only in IDLE (combinational from state).
- IDLE:
  - An accept occurs on In_Valid&&In_Ready at a rising edge.
  - On accept, register A, B and Cin; carry=Cin, idx=0, Err=0, Sum=0; go to ADD.
  - Input changes after the accept are ignored.
- ADD, one digit per cycle for digit idx:
  - t = A_idx + B_idx + carry, 5-bit binary.
  - If t>9: Sum_idx = (t+6)[3:0] and carry=1. Otherwise Sum_idx = t[3:0] and carry=0.
  - Err is set (sticky) if A_idx>9 or B_idx>9. The same correction rule still applies; there is no saturation or abort.
  - If idx==DIGITS-1: Cout=carry-out of this digit; go to DONE. Otherwise idx++.
- Latency: Out_Valid rises exactly DIGITS cycles after the accept edge. DIGITS=1 gives a latency of 1.
- DONE:
  - Out_Valid=1; Sum, Cout and Err are held stable until Out_Valid&&Out_Ready.
  - On that edge: Out_Valid=0, go to IDLE; In_Ready=1 from the next cycle.
  - There is no same-cycle result-consume plus operand-accept. Throughput is one operation per DIGITS+2 cycles minimum.
- Back-pressure: Out_Ready held low keeps the block in DONE indefinitely; In_Valid is ignored during that time.
- Intermediate values: Sum and Cout show partial values during ADD and are only meaningful while Out_Valid=1.
- Reset mid-operation: immediate abort; all registers return to reset values; the operation is lost. There is no partial Out_Valid.
- Wrap-around: a sum of 10^DIGITS or more wraps modulo 10^DIGITS with Cout=1.

Optional Feature:
- Macro: BCD_SUB_EN.
- With the macro defined:
  - An extra port Op (input, 1) is sampled at accept.
  - Op=0: addition as above.
  - Op=1: computes A-B as A + nines'-complement(B) + 1. Each B digit is replaced by 9-B_idx, and the initial carry is forced to 1 (Cin ignored).
  - Cout=1 means A>=B and Sum=A-B.
  - Cout=0 means a borrow occurred and Sum is the ten's complement of B-A.
  - Err checks the original B digits, not the complemented ones.
- Without the macro: Op port absent; add-only behaviour; no complement logic synthesised.

Decomposition:
- Package bcd_adder_pkg holds:
  - the state typedef (IDLE, ADD, DONE);
  - constants DIGIT_W=4, BCD_MAX=9, BCD_CORR=6.
- One natural sub-module: bcd_digit_add, a combinational single-digit BCD adder.
  - Inputs: 4-bit a, 4-bit b, cin.
  - Outputs: 4-bit s, cout, bad (a>9 or b>9).
  - Instantiated once and time-multiplexed by idx.

Test Plan:
- DIGITS=4, A=0x1234, B=0x5678, Cin=0 -> Sum=0x6912, Cout=0, Err=0; Out_Valid exactly 4 cycles after accept.
- A=0x9999, B=0x0001, Cin=0 -> Sum=0x0000, Cout=1 (full-width carry ripple and wrap).
- A=0x0000, B=0x0000, Cin=1, Out_Ready=0 for 5 cycles; a second In_Valid is pulsed meanwhile -> Sum=0x0001 held stable, In_Ready=0, second request ignored; the result is released on Out_Ready=1 and In_Ready=1 the following cycle.
- A=0x00A0, B=0x0000, Cin=0 -> Err=1, Sum=0x0100, Cout=0 (digit 1: 10 corrected to 0 with carry).
- Accept A=0x1111, B=0x2222, then assert Rst during the 2nd ADD cycle -> Out_Valid never asserts; after release In_Ready=1 and Sum=0; a fresh 0x0005+0x0005 then returns 0x0010.
- BCD_SUB_EN, Op=1: A=0x0500, B=0x0123 -> Sum=0x0377, Cout=1; A=0x0123, B=0x0500 -> Sum=0x9623, Cout=0.
